branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the instruction-address and operand width.
REQ-002 Parameter ENTRIES, default 16, power of two >= 2, SHALL set the prediction table depth; IDX = log2(ENTRIES).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Port fetch_pc  input  XLEN  SHALL carry the fetch-stage PC to look up.
REQ-006 Port pred_taken  output  1  SHALL give the fetch-side taken prediction.
REQ-007 Port pred_target  output  XLEN  SHALL give the predicted target; SHALL be fetch_pc+4 when pred_taken=0.
REQ-008 Port ex_valid  input  1  SHALL qualify all ex_* inputs.
REQ-009 Port ex_type  input  3  SHALL give the branch type: 0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL.
REQ-010 Ports ex_rs1, ex_rs2  input  XLEN  SHALL carry the compare operands.
REQ-011 Ports ex_pc, ex_offset  input  XLEN  SHALL carry the branch PC and the sign-extended offset.
REQ-012 Ports ex_pred_taken (1) and ex_pred_target (XLEN), inputs, SHALL carry the prediction made for this instruction at fetch.
REQ-013 Port redirect_valid  output  1  SHALL pulse for one cycle on a mispredict.
REQ-014 Port redirect_pc  output  XLEN  SHALL give the corrected fetch PC.
REQ-015 Ports stat_branches, stat_mispredicts  output  32  SHALL count resolved branches and mispredicts.

Function
REQ-016 Table entry SHALL hold valid(1), tag (XLEN-IDX-2 bits = ex_pc[XLEN-1:IDX+2]), target(XLEN), ctr(2); index = pc[IDX+1:2].
REQ-017 Lookup SHALL be combinational from registered state: hit = valid && tag match; pred_taken = hit && ctr>=2; pred_target = entry target on taken, else fetch_pc+4.
REQ-018 Resolution, when ex_valid && ex_type!=0: taken per type (BEQ ==, BNE !=, BLT/BGE signed, BLTU/BGEU unsigned, JAL always); target = ex_pc+ex_offset mod 2^XLEN.
REQ-019 Mispredict SHALL be (taken != ex_pred_taken) || (taken && ex_pred_target != target).
REQ-020 redirect_valid/redirect_pc SHALL be registered: asserted the cycle after resolution (latency 1); redirect_pc = target if taken else ex_pc+4 (mod 2^XLEN).
REQ-021 redirect_valid SHALL be 0 in any cycle following one with no mispredict; back-to-back mispredicts SHALL give back-to-back pulses.
REQ-022 Update on hit: ctr saturating +1 if taken, -1 if not (no wrap past 3 or 0); target overwritten when taken.
REQ-023 Update on miss: allocate only if taken, writing valid=1, tag, target, ctr=2; a not-taken miss SHALL leave the table untouched.
REQ-024 ex_type=0 or ex_valid=0 SHALL cause no table, stat or redirect change.
REQ-025 Same-cycle lookup and update of one index SHALL return the pre-update entry (read-before-write).
REQ-026 stat_branches +1 per resolved branch, stat_mispredicts +1 per mispredict; both SHALL saturate at 2^32-1.

Reset
REQ-027 rst=1 SHALL immediately clear all valid bits, set all ctr to 1, clear both stats, and drive redirect_valid=0, redirect_pc=0, pred_taken=0, with no clock edge required.
REQ-028 rst asserted mid-operation SHALL drop any pending redirect; the first resolution after release SHALL see an empty table.

Verification
REQ-029 Reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0x104, stats 0.
REQ-030 BEQ ex_pc=0x100, rs1=rs2=5, offset=0x20, pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x120; fetch_pc=0x100 then pred_taken=1, pred_target=0x120.
REQ-031 BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken.
REQ-032 Four not-taken resolutions of an allocated entry -> ctr 2->1->0->0; pred_taken=0 after first.
REQ-033 JAL ex_pc=0xFFFFFFF0, offset=0x20 -> redirect_pc=0x10 (wrap).
REQ-034 Predicted taken to 0x140, actual target 0x120 -> redirect to 0x120, stat_mispredicts +1; rst mid-pulse -> redirect_valid=0 at once.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged table of 2-bit counters and targets, looked up at fetch
// and trained at execute, with a registered one-cycle redirect on mispredict.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [2:0]      ex_type,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_offset,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6,
        BR_JAL  = 3'd7
    } br_type_e;

    logic            tbl_valid  [ENTRIES];
    logic [TAGW-1:0] tbl_tag    [ENTRIES];
    logic [XLEN-1:0] tbl_target [ENTRIES];
    logic [1:0]      tbl_ctr    [ENTRIES];

    logic [IDX-1:0]  f_idx;
    logic            f_hit;
    logic [IDX-1:0]  e_idx;
    logic            e_hit;
    logic            resolve;
    logic            actual_taken;
    logic [XLEN-1:0] actual_target;
    logic [XLEN-1:0] fix_pc;
    logic            mispredict;

    // Fetch lookup reads only registered table state, so a same-cycle update is not visible yet.
    assign f_idx       = fetch_pc[IDX+1:2];
    assign f_hit       = tbl_valid[f_idx] && (tbl_tag[f_idx] == fetch_pc[XLEN-1:IDX+2]);
    assign pred_taken  = f_hit && tbl_ctr[f_idx][1];
    assign pred_target = pred_taken ? tbl_target[f_idx] : fetch_pc + XLEN'(4);

    // ex_* is a valid-qualified stream with no ready: a resolution is consumed in the cycle
    // ex_valid is high and ex_type is not NONE; otherwise the ex_* fields are ignored.
    assign resolve       = ex_valid && (ex_type != BR_NONE);
    assign e_idx         = ex_pc[IDX+1:2];
    assign e_hit         = tbl_valid[e_idx] && (tbl_tag[e_idx] == ex_pc[XLEN-1:IDX+2]);
    assign actual_target = ex_pc + ex_offset;
    assign fix_pc        = actual_taken ? actual_target : ex_pc + XLEN'(4);

    always_comb begin
        actual_taken = 1'b0;
        case (br_type_e'(ex_type))
            BR_BEQ:  actual_taken = (ex_rs1 == ex_rs2);
            BR_BNE:  actual_taken = (ex_rs1 != ex_rs2);
            BR_BLT:  actual_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            BR_BGE:  actual_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            BR_BLTU: actual_taken = (ex_rs1 <  ex_rs2);
            BR_BGEU: actual_taken = (ex_rs1 >= ex_rs2);
            BR_JAL:  actual_taken = 1'b1;
            default: actual_taken = 1'b0;
        endcase
    end

    assign mispredict = resolve &&
                        ((actual_taken != ex_pred_taken) ||
                         (actual_taken && (ex_pred_target != actual_target)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
                tbl_ctr[i]    <= 2'd1;
            end
        end else if (resolve) begin
            if (e_hit) begin
                if (actual_taken) begin
                    tbl_target[e_idx] <= actual_target;
                    if (tbl_ctr[e_idx] != 2'd3)
                        tbl_ctr[e_idx] <= tbl_ctr[e_idx] + 2'd1;
                end else if (tbl_ctr[e_idx] != 2'd0) begin
                    tbl_ctr[e_idx] <= tbl_ctr[e_idx] - 2'd1;
                end
            end else if (actual_taken) begin
                tbl_valid[e_idx]  <= 1'b1;
                tbl_tag[e_idx]    <= ex_pc[XLEN-1:IDX+2];
                tbl_target[e_idx] <= actual_target;
                tbl_ctr[e_idx]    <= 2'd2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict)
                redirect_pc <= fix_pc;
            if (resolve && (stat_branches != '1))
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, reset corner sequences and randomized
// traffic, all checked against a table-of-entries reference model.
module tb_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int IDX     = $clog2(ENTRIES);

    typedef struct {
        logic            ex_valid;
        logic [2:0]      ex_type;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] off;
        logic            pt;
        logic [XLEN-1:0] ptgt;
        logic [XLEN-1:0] fetch;
        logic            e_pt;
        logic [XLEN-1:0] e_ptgt;
        logic            e_rv;
        logic [XLEN-1:0] e_rpc;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [XLEN-1:0] fetch_pc = '0;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid = 1'b0;
    logic [2:0]      ex_type = '0;
    logic [XLEN-1:0] ex_rs1 = '0, ex_rs2 = '0, ex_pc = '0, ex_offset = '0;
    logic            ex_pred_taken = 1'b0;
    logic [XLEN-1:0] ex_pred_target = '0;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     stat_branches, stat_mispredicts;

    int n_vec  = 0;
    int n_miss = 0;

    logic [XLEN:0] exp_q[$];

    // Reference model state: one record per table slot, counters as plain integers.
    bit              m_valid [ENTRIES];
    logic [XLEN-1:0] m_tag   [ENTRIES];
    logic [XLEN-1:0] m_tgt   [ENTRIES];
    int              m_ctr   [ENTRIES];
    longint          m_br, m_mp;

    vec_t vecs[17];

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_type(ex_type), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pc(ex_pc), .ex_offset(ex_offset),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_br = 0;
        m_mp = 0;
        exp_q.delete();
    endtask

    task automatic model_lookup(input logic [XLEN-1:0] pc, output logic t, output logic [XLEN-1:0] tgt);
        int i;
        i = int'((pc >> 2) % ENTRIES);
        t = m_valid[i] && (m_tag[i] == (pc >> (IDX + 2))) && (m_ctr[i] >= 2);
        tgt = t ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_resolve(input vec_t v);
        logic            taken;
        logic            mis;
        logic [XLEN-1:0] target;
        int              i;
        bit              hit;
        if (!v.ex_valid || v.ex_type == 3'd0) begin
            exp_q.push_back({1'b0, {XLEN{1'b0}}});
            return;
        end
        case (v.ex_type)
            3'd1: taken = (v.rs1 == v.rs2);
            3'd2: taken = (v.rs1 != v.rs2);
            3'd3: taken = ($signed(v.rs1) < $signed(v.rs2));
            3'd4: taken = ($signed(v.rs1) >= $signed(v.rs2));
            3'd5: taken = (v.rs1 < v.rs2);
            3'd6: taken = (v.rs1 >= v.rs2);
            default: taken = 1'b1;
        endcase
        target = v.pc + v.off;
        mis = (taken != v.pt) || (taken && (v.ptgt != target));
        i = int'((v.pc >> 2) % ENTRIES);
        hit = m_valid[i] && (m_tag[i] == (v.pc >> (IDX + 2)));
        if (hit) begin
            m_ctr[i] = taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (taken) m_tgt[i] = target;
        end else if (taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = v.pc >> (IDX + 2);
            m_tgt[i]   = target;
            m_ctr[i]   = 2;
        end
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (mis && m_mp < 64'hFFFF_FFFF) m_mp++;
        exp_q.push_back({mis, taken ? target : v.pc + 32'd4});
    endtask

    // Drives one cycle; inputs change #1 after a rising edge and outputs are sampled #1 later.
    task automatic apply(input vec_t v, input bit use_exp);
        logic            mt;
        logic [XLEN-1:0] mtg;
        logic [XLEN:0]   e;
        ex_valid = v.ex_valid; ex_type = v.ex_type; ex_rs1 = v.rs1; ex_rs2 = v.rs2;
        ex_pc = v.pc; ex_offset = v.off; ex_pred_taken = v.pt; ex_pred_target = v.ptgt;
        fetch_pc = v.fetch;
        #1;
        model_lookup(v.fetch, mt, mtg);
        check("pred_taken", {63'd0, pred_taken}, {63'd0, mt});
        check("pred_target", {32'd0, pred_target}, {32'd0, mtg});
        if (use_exp) begin
            check("vec_pred_taken", {63'd0, pred_taken}, {63'd0, v.e_pt});
            check("vec_pred_target", {32'd0, pred_target}, {32'd0, v.e_ptgt});
        end
        model_resolve(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("redirect_valid", {63'd0, redirect_valid}, {63'd0, e[XLEN]});
            if (e[XLEN]) check("redirect_pc", {32'd0, redirect_pc}, {32'd0, e[XLEN-1:0]});
        end
        if (use_exp) begin
            check("vec_redirect_valid", {63'd0, redirect_valid}, {63'd0, v.e_rv});
            if (v.e_rv) check("vec_redirect_pc", {32'd0, redirect_pc}, {32'd0, v.e_rpc});
        end
        check("stat_branches", {32'd0, stat_branches}, m_br);
        check("stat_mispredicts", {32'd0, stat_mispredicts}, m_mp);
    endtask

    task automatic check_reset_outputs(input string tag);
        fetch_pc = 32'h100;
        #1;
        check({tag, "_redirect_valid"}, {63'd0, redirect_valid}, 64'd0);
        check({tag, "_redirect_pc"}, {32'd0, redirect_pc}, 64'd0);
        check({tag, "_pred_taken"}, {63'd0, pred_taken}, 64'd0);
        check({tag, "_pred_target"}, {32'd0, pred_target}, 64'h104);
        check({tag, "_stat_branches"}, {32'd0, stat_branches}, 64'd0);
        check({tag, "_stat_mispredicts"}, {32'd0, stat_mispredicts}, 64'd0);
    endtask

    function automatic logic [XLEN-1:0] rand_pc();
        logic [XLEN-1:0] base;
        case ($urandom_range(0, 2))
            0: base = 32'h0000_0100;
            1: base = 32'h0000_1000;
            default: base = 32'hFFFF_FF00;
        endcase
        return base + (32'($urandom_range(0, 3)) << 2);
    endfunction

    initial begin
        vec_t            rv;
        logic            mt;
        logic [XLEN-1:0] mtg;

        //            ev  ty  rs1           rs2  pc            off    pt  ptgt          fetch         ept ept_tgt       erv erpc
        vecs[0]  = '{1'b0,3'd0,32'd0,       32'd0,32'h0,       32'h0, 1'b0,32'h0,       32'h100,      1'b0,32'h104,     1'b0,32'h0};
        vecs[1]  = '{1'b1,3'd1,32'd5,       32'd5,32'h100,     32'h20,1'b0,32'h104,     32'h100,      1'b0,32'h104,     1'b1,32'h120};
        vecs[2]  = '{1'b0,3'd0,32'd0,       32'd0,32'h0,       32'h0, 1'b0,32'h0,       32'h100,      1'b1,32'h120,     1'b0,32'h0};
        vecs[3]  = '{1'b1,3'd3,32'hFFFFFFFF,32'd1,32'h204,     32'h10,1'b1,32'h214,     32'h204,      1'b0,32'h208,     1'b0,32'h0};
        vecs[4]  = '{1'b1,3'd5,32'hFFFFFFFF,32'd1,32'h208,     32'h10,1'b0,32'h20C,     32'h208,      1'b0,32'h20C,     1'b0,32'h0};
        vecs[5]  = '{1'b0,3'd0,32'd0,       32'd0,32'h0,       32'h0, 1'b0,32'h0,       32'h204,      1'b1,32'h214,     1'b0,32'h0};
        vecs[6]  = '{1'b0,3'd0,32'd0,       32'd0,32'h0,       32'h0, 1'b0,32'h0,       32'h208,      1'b0,32'h20C,     1'b0,32'h0};
        vecs[7]  = '{1'b1,3'd2,32'd3,       32'd3,32'h100,     32'h20,1'b1,32'h120,     32'h100,      1'b1,32'h120,     1'b1,32'h104};
        vecs[8]  = '{1'b1,3'd2,32'd3,       32'd3,32'h100,     32'h20,1'b0,32'h104,     32'h100,      1'b0,32'h104,     1'b0,32'h0};
        vecs[9]  = '{1'b1,3'd2,32'd3,       32'd3,32'h100,     32'h20,1'b0,32'h104,     32'h100,      1'b0,32'h104,     1'b0,32'h0};
        vecs[10] = '{1'b1,3'd2,32'd3,       32'd3,32'h100,     32'h20,1'b0,32'h104,     32'h100,      1'b0,32'h104,     1'b0,32'h0};
        vecs[11] = '{1'b1,3'd1,32'd7,       32'd7,32'h100,     32'h20,1'b0,32'h104,     32'h100,      1'b0,32'h104,     1'b1,32'h120};
        vecs[12] = '{1'b0,3'd0,32'd0,       32'd0,32'h0,       32'h0, 1'b0,32'h0,       32'h100,      1'b0,32'h104,     1'b0,32'h0};
        vecs[13] = '{1'b1,3'd7,32'd0,       32'd0,32'hFFFFFFF0,32'h20,1'b0,32'hFFFFFFF4,32'hFFFFFFF0, 1'b0,32'hFFFFFFF4,1'b1,32'h10};
        vecs[14] = '{1'b1,3'd0,32'd1,       32'd2,32'h100,     32'h40,1'b1,32'h999,     32'hFFFFFFF0, 1'b1,32'h10,      1'b0,32'h0};
        vecs[15] = '{1'b1,3'd1,32'd9,       32'd9,32'h100,     32'h20,1'b1,32'h140,     32'h100,      1'b0,32'h104,     1'b1,32'h120};
        vecs[16] = '{1'b1,3'd2,32'd1,       32'd2,32'h100,     32'h40,1'b1,32'h120,     32'h100,      1'b1,32'h120,     1'b1,32'h140};

        // Reset is asserted before the first clock edge, so outputs must settle from rst alone.
        #2 rst = 1'b1;
        model_reset();
        check_reset_outputs("por");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) apply(vecs[i], 1'b1);

        // The last vector leaves a redirect pulse live; reset mid-cycle must drop it at once.
        check("pulse_live", {63'd0, redirect_valid}, 64'd1);
        #2 rst = 1'b1;
        model_reset();
        check_reset_outputs("mid");
        @(posedge clk); #1;
        rst = 1'b0;
        rv = '{1'b1,3'd1,32'd4,32'd4,32'h100,32'h20,1'b1,32'h120,32'h100,1'b0,32'h104,1'b0,32'h0};
        apply(rv, 1'b1);
        rv = '{1'b0,3'd0,32'd0,32'd0,32'h0,32'h0,1'b0,32'h0,32'h100,1'b1,32'h120,1'b0,32'h0};
        apply(rv, 1'b1);

        for (int n = 0; n < 600; n++) begin
            rv = '{default: '0};
            rv.ex_valid = ($urandom_range(0, 3) != 0);
            rv.ex_type  = 3'($urandom_range(0, 7));
            rv.pc       = rand_pc();
            case ($urandom_range(0, 3))
                0: rv.off = 32'h20;
                1: rv.off = 32'h40;
                2: rv.off = 32'hFFFF_FFC0;
                default: rv.off = $urandom & 32'hFFFF_FFFC;
            endcase
            rv.rs1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2;
            rv.rs2 = ($urandom_range(0, 2) == 0) ? rv.rs1 : 32'($urandom_range(0, 4)) - 32'd2;
            model_lookup(rv.pc, mt, mtg);
            if ($urandom_range(0, 3) != 0) begin
                rv.pt   = mt;
                rv.ptgt = mtg;
            end else begin
                rv.pt   = 1'($urandom_range(0, 1));
                rv.ptgt = ($urandom_range(0, 1) != 0) ? rv.pc + rv.off : rand_pc();
            end
            rv.fetch = ($urandom_range(0, 1) != 0) ? rv.pc : rand_pc();
            apply(rv, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
